// File: rtl/cuckoo_chime_ctrl.sv
// Purpose: plays the hourly cuckoo chime (N = hour in 12h form) and shares the buzzer with the alarm.
// Latency: an accepted top-of-hour trigger enters ON the next cycle; o_buzz is registered (1-cycle delay).
// Backpressure: none; triggers that arrive while busy, muted or alarmed are dropped, not queued.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_hour/i_min/i_sec  timekeeper value (hour 0..23, min/sec 0..59)
//   i_mute              one-cycle pulse, cancels a running sequence
//   i_alarm_req         level, alarm owns the buzzer while high (also cancels the chime)
//   i_alarm_tone        alarm waveform passed to the buzzer while i_alarm_req=1
//   o_buzz              registered buzzer drive
//   o_busy              high while the chime sequence is in ON or OFF
//   o_remain            chimes not yet started or still sounding
module cuckoo_chime_ctrl #(
  parameter int unsigned ON_CYC    = 50_000_000,
  parameter int unsigned OFF_CYC   = 50_000_000,
  parameter int unsigned TONE_DIV  = 25_000,
  parameter int unsigned QUIET_END = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_mute,
  input  logic       i_alarm_req,
  input  logic       i_alarm_tone,
  output logic       o_buzz,
  output logic       o_busy,
  output logic [3:0] o_remain
);

  // One phase counter serves both ON and OFF, so size it for the longer one.
  localparam int unsigned PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TN_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [PH_W-1:0] ON_LAST   = PH_W'(ON_CYC - 1);
  localparam logic [PH_W-1:0] OFF_LAST  = PH_W'(OFF_CYC - 1);
  localparam logic [TN_W-1:0] TONE_LAST = TN_W'(TONE_DIV - 1);
  localparam logic [4:0]      QUIET_H   = 5'(QUIET_END);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase_cnt;
  logic [TN_W-1:0] tone_cnt;
  logic            tone;
  logic            prev_cond;

  logic            trig_cond;
  logic            trig;
  logic            abort;
  logic [4:0]      hour12;
  logic [3:0]      n_chime;
  logic [3:0]      remain_dec;

  always_comb begin
    trig_cond  = (i_min == 6'd0) && (i_sec == 6'd0) &&
                 (i_hour >= QUIET_H) && (i_hour <= 5'd23);
    trig       = trig_cond && !prev_cond;
    abort      = i_mute || i_alarm_req;
    // 12-hour form, with noon/midnight sounding twelve times.
    hour12     = (i_hour >= 5'd12) ? (i_hour - 5'd12) : i_hour;
    n_chime    = (hour12 == 5'd0) ? 4'd12 : 4'(hour12);
    remain_dec = o_remain - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      tone_cnt  <= '0;
      tone      <= 1'b0;
      // Starts high so power-up during hh:00:00 is not seen as a new hour.
      prev_cond <= 1'b1;
      o_buzz    <= 1'b0;
      o_busy    <= 1'b0;
      o_remain  <= 4'd0;
    end else begin
      prev_cond <= trig_cond;
      o_buzz    <= i_alarm_req ? i_alarm_tone : ((state == S_ON) && tone);

      case (state)
        S_IDLE: begin
          // Mute and alarm both outrank the trigger; a dropped trigger is gone for good.
          if (trig && !abort) begin
            state     <= S_ON;
            o_busy    <= 1'b1;
            o_remain  <= n_chime;
            phase_cnt <= '0;
            tone_cnt  <= '0;
            tone      <= 1'b0;
          end
        end

        S_ON: begin
          if (abort) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_remain  <= 4'd0;
            phase_cnt <= '0;
            tone_cnt  <= '0;
            tone      <= 1'b0;
          end else if (phase_cnt == ON_LAST) begin
            o_remain  <= remain_dec;
            phase_cnt <= '0;
            tone_cnt  <= '0;
            tone      <= 1'b0;
            // The last chime ends the sequence directly, without a trailing gap.
            if (remain_dec == 4'd0) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= S_OFF;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
            if (tone_cnt == TONE_LAST) begin
              tone_cnt <= '0;
              tone     <= ~tone;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end

        S_OFF: begin
          if (abort) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_remain  <= 4'd0;
            phase_cnt <= '0;
          end else if (phase_cnt == OFF_LAST) begin
            state     <= S_ON;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          o_busy   <= 1'b0;
          o_remain <= 4'd0;
        end
      endcase
    end
  end

endmodule
